mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Moore-style FSM that sequences the multi-cycle MIPS datapath: IFU/PC, IR, GPR, ALU, EXT and dm_1k.
- Replaces the single-cycle combinational controller in the multi-cycle core.
- Decodes `opcode`/`funct` from the IR output and drives all write strobes and mux selects, one phase per clock.
- Supports a data-memory ready handshake so slow memory stalls the sequence.

Parameters:
- MEM_WAIT_MAX, 15: maximum MEM-phase stall cycles before the access is abandoned. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], stable from DCD until the next FETCH
- funct  in  6  IR[5:0]
- Zero  in  1  ALU result == 0, used by beq
- MemRdy  in  1  dm_1k access complete this cycle
- PCWr  out  1  PC register write enable
- IRWr  out  1  IR write enable
- RegWr  out  1  GPR write enable
- MemWr  out  1  dm_1k write enable
- MemRd  out  1  dm_1k read request
- ALUSrc  out  1  0 = B, 1 = EXT
- RegDst  out  2  0 = rt, 1 = rd, 2 = $31
- Mem2Reg  out  2  0 = ALU, 1 = RAM, 2 = PC (already PC+4)
- NPCSel  out  2  0 = PC+4, 1 = branch, 2 = j-target, 3 = register
- EXTOp  out  2  0 = zero, 1 = sign, 2 = high (lui)
- ALUOp  out  3  0 = ADD, 1 = SUB, 2 = OR, 3 = SLT
- MemTO  out  1  one-cycle pulse when a MEM access times out
- State  out  4  current state, for debug

Behaviour:
- Reset: while rst = 1 at a clk edge, State <= FETCH and the wait counter <= 0. During any cycle with rst = 1, all strobes (PCWr, IRWr, RegWr, MemWr, MemRd, MemTO) = 0 and all selects = 0. Reset mid-instruction aborts it with no further writes.
- States: FETCH = 0, DCD = 1, EXE_R = 2, EXE_I = 3, MEMADR = 4, MEM_RD = 5, MEM_WR = 6, WB_ALU = 7, WB_MEM = 8, BRANCH = 9, JUMP = 10.
- FETCH: IRWr = 1, PCWr = 1, NPCSel = 0. Next state is DCD.
- DCD: no strobes asserted. Next state by opcode:
  - R-type (000000): addu 100001, subu 100011, slt 101010 go to EXE_R; jr 001000 goes to JUMP.
  - ori 001101, lui 001111, addiu 001001 go to EXE_I.
  - lw 100011, sw 101011 go to MEMADR.
  - beq 000100 goes to BRANCH.
  - j 000010, jal 000011 go to JUMP.
  - Any other opcode/funct goes to FETCH as a NOP; no register or memory write.
- EXE_R: ALUSrc = 0; ALUOp is ADD for addu, SUB for subu, SLT for slt. Next state is WB_ALU with RegDst = 1.
- EXE_I: ALUSrc = 1.
  - ori: EXTOp = 0, ALUOp = OR.
  - lui: EXTOp = 2, ALUOp = OR (the rs field is 0).
  - addiu: EXTOp = 1, ALUOp = ADD.
  - Next state is WB_ALU with RegDst = 0.
- WB_ALU: RegWr = 1, Mem2Reg = 0; ALU controls are held from the EXE state. Next state is FETCH.
- MEMADR: ALUSrc = 1, EXTOp = 1, ALUOp = ADD. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD / MEM_WR: MemRd = 1 (or MemWr = 1), address controls held.
  - MemRdy = 0: stay in the state and increment the wait counter.
  - MemRdy = 1: MEM_RD goes to WB_MEM; MEM_WR goes to FETCH.
  - MemRdy sampled in the same cycle as entry completes the access with zero stall.
  - Timeout: when the counter reaches MEM_WAIT_MAX (MEM_WAIT_MAX > 0) with MemRdy still 0, assert MemTO for 1 cycle and go to FETCH. No GPR write occurs.
  - If MemRdy = 1 in the timeout cycle, the access completes normally and MemTO stays 0.
  - The counter clears on leaving a MEM state; it is 4 bits wide and saturates.
- WB_MEM: RegWr = 1, RegDst = 0, Mem2Reg = 1. Next state is FETCH.
- BRANCH: ALUSrc = 0, ALUOp = SUB, NPCSel = 1, PCWr = Zero. Next state is FETCH.
- JUMP:
  - j: NPCSel = 2, PCWr = 1.
  - jal: NPCSel = 2, PCWr = 1, RegWr = 1, RegDst = 2, Mem2Reg = 2. The PC value seen here is the old PC+4; the GPR write and PC update commit at the same edge.
  - jr: NPCSel = 3, PCWr = 1.
  - Next state is FETCH.
- Latencies (clocks per instruction, no stall): R / I = 4, lw = 5, sw = 4, beq = 3, j / jal / jr = 3, illegal = 2.
- Outputs are a function of State, opcode, funct and Zero only. There is no combinational path from MemRdy to any strobe except MemTO.

Decomposition:
- Shared macro file (the existing macro.v) holds:
  - state encodings;
  - opcode and funct constants;
  - REGDST_*, MEM2REG_*, NPC_SEL_*, EXTOP_*, ALUOP_*, ALUSRC_* encodings.
- One sub-module, mc_decode: a combinational opcode/funct-to-instruction-class decoder (R_ALU, I_ALU, LOAD, STORE, BRANCH, JMP, JAL, JR, ILLEGAL), used by DCD and by the per-state output logic.
- The FSM register and the wait counter stay in mc_controller.

Test Plan:
- addu ($1 = 3, $2 = 4 → $3): State sequence 0, 1, 2, 7, 0. RegWr high only in WB_ALU with RegDst = 1; $3 = 7 after 4 clocks.
- lw with MemRdy low for 3 cycles: State 0, 1, 4, 5, 5, 5, 5, 8, 0 (8 clocks). MemRd high in all MEM_RD cycles; RegWr with Mem2Reg = 1 once.
- sw with MemRdy stuck 0, MEM_WAIT_MAX = 15: after 15 stall cycles MemTO pulses once, the next state is FETCH, and RegWr stays 0 throughout.
- beq with Zero = 1, then with Zero = 0: PCWr = 1 / 0 in BRANCH with NPCSel = 1. Both take 3 clocks.
- jal at PC 0x3000: in JUMP, RegWr = 1, RegDst = 2, Mem2Reg = 2, PCWr = 1, NPCSel = 2. $31 = 0x3004.
- Assert rst in MEM_RD, and separately for opcode 0x3F: rst forces all strobes 0 and State = 0 the next clock. The illegal opcode gives State 0, 1, 0 with no RegWr/MemWr.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: shared definitions for the multi-cycle MIPS controller.
// Holds the FSM state encodings, opcode/funct constants, datapath select
// encodings and the instruction-class type produced by mc_decode.
package mc_controller_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DCD    = 4'd1,
        EXE_R  = 4'd2,
        EXE_I  = 4'd3,
        MEMADR = 4'd4,
        MEM_RD = 4'd5,
        MEM_WR = 4'd6,
        WB_ALU = 4'd7,
        WB_MEM = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10
    } state_t;

    typedef enum logic [3:0] {
        CLS_ILLEGAL,
        CLS_R_ALU,
        CLS_I_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JMP,
        CLS_JAL,
        CLS_JR
    } instr_cls_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type funct codes
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Datapath select encodings
    localparam logic [1:0] REGDST_RT    = 2'd0;
    localparam logic [1:0] REGDST_RD    = 2'd1;
    localparam logic [1:0] REGDST_RA    = 2'd2;
    localparam logic [1:0] MEM2REG_ALU  = 2'd0;
    localparam logic [1:0] MEM2REG_RAM  = 2'd1;
    localparam logic [1:0] MEM2REG_PC   = 2'd2;
    localparam logic [1:0] NPC_SEL_PC4  = 2'd0;
    localparam logic [1:0] NPC_SEL_BR   = 2'd1;
    localparam logic [1:0] NPC_SEL_J    = 2'd2;
    localparam logic [1:0] NPC_SEL_REG  = 2'd3;
    localparam logic [1:0] EXTOP_ZERO   = 2'd0;
    localparam logic [1:0] EXTOP_SIGN   = 2'd1;
    localparam logic [1:0] EXTOP_HIGH   = 2'd2;
    localparam logic [2:0] ALUOP_ADD    = 3'd0;
    localparam logic [2:0] ALUOP_SUB    = 3'd1;
    localparam logic [2:0] ALUOP_OR     = 3'd2;
    localparam logic [2:0] ALUOP_SLT    = 3'd3;
    localparam logic       ALUSRC_B     = 1'b0;
    localparam logic       ALUSRC_EXT   = 1'b1;

    // Decoder result: instruction class plus the ALU/EXT controls that the
    // EXE and WB_ALU phases apply for ALU-class instructions.
    typedef struct packed {
        instr_cls_t cls;
        logic [2:0] aluop;
        logic [1:0] extop;
    } dec_t;

endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: controller <-> datapath signal bundle.
//   IR fields : opcode, funct          (datapath -> controller)
//   status    : Zero, MemRdy           (datapath -> controller)
//   strobes   : PCWr, IRWr, RegWr, MemWr, MemRd, MemTO
//   selects   : ALUSrc, RegDst, Mem2Reg, NPCSel, EXTOp, ALUOp
//   debug     : State
// master = controller side, slave = datapath side.
interface mc_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       Zero;
    logic       MemRdy;
    logic       PCWr;
    logic       IRWr;
    logic       RegWr;
    logic       MemWr;
    logic       MemRd;
    logic       ALUSrc;
    logic [1:0] RegDst;
    logic [1:0] Mem2Reg;
    logic [1:0] NPCSel;
    logic [1:0] EXTOp;
    logic [2:0] ALUOp;
    logic       MemTO;
    logic [3:0] State;

    modport master (
        input  opcode, funct, Zero, MemRdy,
        output PCWr, IRWr, RegWr, MemWr, MemRd, ALUSrc, RegDst, Mem2Reg,
               NPCSel, EXTOp, ALUOp, MemTO, State
    );

    modport slave (
        output opcode, funct, Zero, MemRdy,
        input  PCWr, IRWr, RegWr, MemWr, MemRd, ALUSrc, RegDst, Mem2Reg,
               NPCSel, EXTOp, ALUOp, MemTO, State
    );
endinterface

// File: rtl/mc_controller_decode.sv
// mc_decode: combinational opcode/funct -> instruction class decoder.
//   i_opcode : IR[31:26]
//   i_funct  : IR[5:0]
//   o_dec    : class (R_ALU, I_ALU, LOAD, STORE, BRANCH, JMP, JAL, JR,
//              ILLEGAL) plus ALUOp/EXTOp for the ALU classes
module mc_decode
    import mc_controller_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output dec_t       o_dec
);

    always_comb begin
        o_dec.cls   = CLS_ILLEGAL;
        o_dec.aluop = ALUOP_ADD;
        o_dec.extop = EXTOP_ZERO;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADDU: begin o_dec.cls = CLS_R_ALU; o_dec.aluop = ALUOP_ADD; end
                    FN_SUBU: begin o_dec.cls = CLS_R_ALU; o_dec.aluop = ALUOP_SUB; end
                    FN_SLT:  begin o_dec.cls = CLS_R_ALU; o_dec.aluop = ALUOP_SLT; end
                    FN_JR:   o_dec.cls = CLS_JR;
                    default: o_dec.cls = CLS_ILLEGAL;
                endcase
            end
            OP_ORI: begin
                o_dec.cls   = CLS_I_ALU;
                o_dec.aluop = ALUOP_OR;
                o_dec.extop = EXTOP_ZERO;
            end
            // rs is $0 for lui, so OR passes the shifted immediate through
            OP_LUI: begin
                o_dec.cls   = CLS_I_ALU;
                o_dec.aluop = ALUOP_OR;
                o_dec.extop = EXTOP_HIGH;
            end
            OP_ADDIU: begin
                o_dec.cls   = CLS_I_ALU;
                o_dec.aluop = ALUOP_ADD;
                o_dec.extop = EXTOP_SIGN;
            end
            OP_LW:   o_dec.cls = CLS_LOAD;
            OP_SW:   o_dec.cls = CLS_STORE;
            OP_BEQ:  o_dec.cls = CLS_BRANCH;
            OP_J:    o_dec.cls = CLS_JMP;
            OP_JAL:  o_dec.cls = CLS_JAL;
            default: o_dec.cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM sequencing the multi-cycle MIPS datapath.
//   clk, rst : clock, synchronous active-high reset
//   mc       : mc_controller_if.master (IR fields, Zero, MemRdy in;
//              write strobes, mux selects, MemTO and State out)
// MEM_WAIT_MAX bounds the MEM-phase stall; 0 disables the timeout.
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic            clk,
    input  logic            rst,
    mc_controller_if.master mc
);

    // Wait counter is 4 bits, so larger limits clamp to its saturation value.
    localparam logic [3:0] WAIT_LIM = (MEM_WAIT_MAX > 15) ? 4'd15 : 4'(MEM_WAIT_MAX);
    localparam bit         TO_EN    = (MEM_WAIT_MAX != 0);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_wait_cnt;
    dec_t       w_dec;
    logic       w_in_mem;
    logic       w_timeout;

    logic       w_pcwr, w_irwr, w_regwr, w_memwr, w_memrd, w_memto, w_alusrc;
    logic [1:0] w_regdst, w_mem2reg, w_npcsel, w_extop;
    logic [2:0] w_aluop;

    mc_decode u_decode (
        .i_opcode (mc.opcode),
        .i_funct  (mc.funct),
        .o_dec    (w_dec)
    );

    assign w_in_mem  = (r_state == MEM_RD) || (r_state == MEM_WR);
    // MemRdy in the limit cycle wins: the access completes instead.
    assign w_timeout = TO_EN && w_in_mem && !mc.MemRdy && (r_wait_cnt == WAIT_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_in_mem && !mc.MemRdy && !w_timeout)
                r_wait_cnt <= (r_wait_cnt == 4'hF) ? r_wait_cnt : r_wait_cnt + 4'd1;
            else
                r_wait_cnt <= '0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH: w_next = DCD;
            DCD: begin
                case (w_dec.cls)
                    CLS_R_ALU:                  w_next = EXE_R;
                    CLS_I_ALU:                  w_next = EXE_I;
                    CLS_LOAD, CLS_STORE:        w_next = MEMADR;
                    CLS_BRANCH:                 w_next = BRANCH;
                    CLS_JMP, CLS_JAL, CLS_JR:   w_next = JUMP;
                    default:                    w_next = FETCH;
                endcase
            end
            EXE_R, EXE_I: w_next = WB_ALU;
            MEMADR:       w_next = (w_dec.cls == CLS_STORE) ? MEM_WR : MEM_RD;
            MEM_RD: begin
                if (mc.MemRdy)      w_next = WB_MEM;
                else if (w_timeout) w_next = FETCH;
            end
            MEM_WR: begin
                if (mc.MemRdy || w_timeout) w_next = FETCH;
            end
            default: w_next = FETCH;
        endcase
    end

    always_comb begin
        w_pcwr    = 1'b0;
        w_irwr    = 1'b0;
        w_regwr   = 1'b0;
        w_memwr   = 1'b0;
        w_memrd   = 1'b0;
        w_memto   = 1'b0;
        w_alusrc  = ALUSRC_B;
        w_regdst  = REGDST_RT;
        w_mem2reg = MEM2REG_ALU;
        w_npcsel  = NPC_SEL_PC4;
        w_extop   = EXTOP_ZERO;
        w_aluop   = ALUOP_ADD;
        case (r_state)
            FETCH: begin
                w_pcwr = 1'b1;
                w_irwr = 1'b1;
            end
            // WB_ALU shares the EXE decode so the ALU result stays stable
            // while the GPR write commits.
            EXE_R, EXE_I, WB_ALU: begin
                w_alusrc = (w_dec.cls == CLS_I_ALU) ? ALUSRC_EXT : ALUSRC_B;
                w_extop  = w_dec.extop;
                w_aluop  = w_dec.aluop;
                w_regdst = (w_dec.cls == CLS_R_ALU) ? REGDST_RD : REGDST_RT;
                w_regwr  = (r_state == WB_ALU);
            end
            MEMADR, MEM_RD, MEM_WR, WB_MEM: begin
                w_alusrc = ALUSRC_EXT;
                w_extop  = EXTOP_SIGN;
                w_aluop  = ALUOP_ADD;
                w_memrd  = (r_state == MEM_RD);
                w_memwr  = (r_state == MEM_WR);
                w_memto  = w_timeout;
                if (r_state == WB_MEM) begin
                    w_regwr   = 1'b1;
                    w_mem2reg = MEM2REG_RAM;
                end
            end
            BRANCH: begin
                w_aluop  = ALUOP_SUB;
                w_npcsel = NPC_SEL_BR;
                w_pcwr   = mc.Zero;
            end
            JUMP: begin
                w_pcwr = 1'b1;
                case (w_dec.cls)
                    CLS_JR:  w_npcsel = NPC_SEL_REG;
                    CLS_JAL: begin
                        w_npcsel  = NPC_SEL_J;
                        w_regwr   = 1'b1;
                        w_regdst  = REGDST_RA;
                        w_mem2reg = MEM2REG_PC;
                    end
                    default: w_npcsel = NPC_SEL_J;
                endcase
            end
            default: ;
        endcase
        if (rst) begin
            w_pcwr    = 1'b0;
            w_irwr    = 1'b0;
            w_regwr   = 1'b0;
            w_memwr   = 1'b0;
            w_memrd   = 1'b0;
            w_memto   = 1'b0;
            w_alusrc  = 1'b0;
            w_regdst  = '0;
            w_mem2reg = '0;
            w_npcsel  = '0;
            w_extop   = '0;
            w_aluop   = '0;
        end
    end

    assign mc.PCWr    = w_pcwr;
    assign mc.IRWr    = w_irwr;
    assign mc.RegWr   = w_regwr;
    assign mc.MemWr   = w_memwr;
    assign mc.MemRd   = w_memrd;
    assign mc.MemTO   = w_memto;
    assign mc.ALUSrc  = w_alusrc;
    assign mc.RegDst  = w_regdst;
    assign mc.Mem2Reg = w_mem2reg;
    assign mc.NPCSel  = w_npcsel;
    assign mc.EXTOp   = w_extop;
    assign mc.ALUOp   = w_aluop;
    assign mc.State   = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed scoreboard bench for mc_controller.
// Each stimulus cycle pushes the hand-computed expected State/strobes/selects;
// a negedge monitor pops and compares against the DUT outputs.
//   strobe vector order : PCWr IRWr RegWr MemWr MemRd MemTO
//   select vector order : ALUSrc RegDst[1:0] Mem2Reg[1:0] NPCSel[1:0] EXTOp[1:0] ALUOp[2:0]
module tb_mc_controller;

    typedef struct packed {
        logic [3:0]  st;
        logic [5:0]  strb;
        logic [11:0] sel;
    } exp_t;

    logic clk;
    logic rst;
    mc_controller_if mc();

    exp_t  q_exp[$];
    string q_name[$];
    int    checks;
    int    failures;

    mc_controller #(.MEM_WAIT_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .mc  (mc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare the DUT outputs mid-cycle against the queued expectation.
    initial begin
        exp_t  e;
        exp_t  a;
        string n;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                n = q_name.pop_front();
                a = {mc.State, mc.PCWr, mc.IRWr, mc.RegWr, mc.MemWr, mc.MemRd, mc.MemTO,
                     mc.ALUSrc, mc.RegDst, mc.Mem2Reg, mc.NPCSel, mc.EXTOp, mc.ALUOp};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL %s: got st=%0d strb=%b sel=%b, want st=%0d strb=%b sel=%b",
                             n, a.st, a.strb, a.sel, e.st, e.strb, e.sel);
                end
            end
        end
    end

    task automatic cyc(input string nm, input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [3:0] st,
                       input logic [5:0] strb, input logic [11:0] sel);
        @(posedge clk);
        #1;
        rst       = r;
        mc.opcode = op;
        mc.funct  = fn;
        mc.Zero   = z;
        mc.MemRdy = rdy;
        q_exp.push_back('{st: st, strb: strb, sel: sel});
        q_name.push_back(nm);
    endtask

    task automatic fetch_dcd(input string nm, input logic [5:0] op, input logic [5:0] fn);
        cyc({nm, "_fetch"}, 1'b0, op, fn, 1'b0, 1'b0, 4'd0, 6'b110000, 12'b0);
        cyc({nm, "_dcd"},   1'b0, op, fn, 1'b0, 1'b0, 4'd1, 6'b000000, 12'b0);
    endtask

    localparam logic [11:0] SEL_MEM = 12'b1_00_00_00_01_000;

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        mc.opcode = '0;
        mc.funct  = '0;
        mc.Zero   = 1'b0;
        mc.MemRdy = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset", 1'b1, 6'h00, 6'h00, 1'b0, 1'b0, 4'd0, 6'b000000, 12'b0);

        // R-type ALU: 4 clocks each
        fetch_dcd("addu", 6'h00, 6'h21);
        cyc("addu_exe", 1'b0, 6'h00, 6'h21, 1'b0, 1'b0, 4'd2, 6'b000000, 12'b0_01_00_00_00_000);
        cyc("addu_wb",  1'b0, 6'h00, 6'h21, 1'b0, 1'b0, 4'd7, 6'b001000, 12'b0_01_00_00_00_000);
        fetch_dcd("subu", 6'h00, 6'h23);
        cyc("subu_exe", 1'b0, 6'h00, 6'h23, 1'b0, 1'b0, 4'd2, 6'b000000, 12'b0_01_00_00_00_001);
        cyc("subu_wb",  1'b0, 6'h00, 6'h23, 1'b0, 1'b0, 4'd7, 6'b001000, 12'b0_01_00_00_00_001);
        fetch_dcd("slt", 6'h00, 6'h2A);
        cyc("slt_exe",  1'b0, 6'h00, 6'h2A, 1'b0, 1'b0, 4'd2, 6'b000000, 12'b0_01_00_00_00_011);
        cyc("slt_wb",   1'b0, 6'h00, 6'h2A, 1'b0, 1'b0, 4'd7, 6'b001000, 12'b0_01_00_00_00_011);

        // I-type ALU
        fetch_dcd("ori", 6'h0D, 6'h00);
        cyc("ori_exe",   1'b0, 6'h0D, 6'h00, 1'b0, 1'b0, 4'd3, 6'b000000, 12'b1_00_00_00_00_010);
        cyc("ori_wb",    1'b0, 6'h0D, 6'h00, 1'b0, 1'b0, 4'd7, 6'b001000, 12'b1_00_00_00_00_010);
        fetch_dcd("lui", 6'h0F, 6'h00);
        cyc("lui_exe",   1'b0, 6'h0F, 6'h00, 1'b0, 1'b0, 4'd3, 6'b000000, 12'b1_00_00_00_10_010);
        cyc("lui_wb",    1'b0, 6'h0F, 6'h00, 1'b0, 1'b0, 4'd7, 6'b001000, 12'b1_00_00_00_10_010);
        fetch_dcd("addiu", 6'h09, 6'h00);
        cyc("addiu_exe", 1'b0, 6'h09, 6'h00, 1'b0, 1'b0, 4'd3, 6'b000000, 12'b1_00_00_00_01_000);
        cyc("addiu_wb",  1'b0, 6'h09, 6'h00, 1'b0, 1'b0, 4'd7, 6'b001000, 12'b1_00_00_00_01_000);

        // lw with 3 stall cycles: 0,1,4,5,5,5,5,8
        fetch_dcd("lw", 6'h23, 6'h00);
        cyc("lw_madr", 1'b0, 6'h23, 6'h00, 1'b0, 1'b0, 4'd4, 6'b000000, SEL_MEM);
        for (int unsigned i = 0; i < 3; i++)
            cyc("lw_stall", 1'b0, 6'h23, 6'h00, 1'b0, 1'b0, 4'd5, 6'b000010, SEL_MEM);
        cyc("lw_rdy",  1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 4'd5, 6'b000010, SEL_MEM);
        cyc("lw_wb",   1'b0, 6'h23, 6'h00, 1'b0, 1'b0, 4'd8, 6'b001000, 12'b1_00_01_00_01_000);

        // sw, ready on entry (zero stall)
        fetch_dcd("sw", 6'h2B, 6'h00);
        cyc("sw_madr", 1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, 4'd4, 6'b000000, SEL_MEM);
        cyc("sw_wr",   1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, 4'd6, 6'b000100, SEL_MEM);

        // sw timeout: 15 stalls, MemTO on the 16th MEM_WR cycle, then FETCH
        fetch_dcd("swto", 6'h2B, 6'h00);
        cyc("swto_madr", 1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, 4'd4, 6'b000000, SEL_MEM);
        for (int unsigned i = 0; i < 15; i++)
            cyc("swto_stall", 1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, 4'd6, 6'b000100, SEL_MEM);
        cyc("swto_pulse", 1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, 4'd6, 6'b000101, SEL_MEM);

        // sw with MemRdy arriving exactly in the limit cycle: no MemTO
        fetch_dcd("swlim", 6'h2B, 6'h00);
        cyc("swlim_madr", 1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, 4'd4, 6'b000000, SEL_MEM);
        for (int unsigned i = 0; i < 15; i++)
            cyc("swlim_stall", 1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, 4'd6, 6'b000100, SEL_MEM);
        cyc("swlim_rdy", 1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, 4'd6, 6'b000100, SEL_MEM);

        // beq taken / not taken
        fetch_dcd("beq1", 6'h04, 6'h00);
        cyc("beq1_br", 1'b0, 6'h04, 6'h00, 1'b1, 1'b0, 4'd9, 6'b100000, 12'b0_00_00_01_00_001);
        fetch_dcd("beq0", 6'h04, 6'h00);
        cyc("beq0_br", 1'b0, 6'h04, 6'h00, 1'b0, 1'b0, 4'd9, 6'b000000, 12'b0_00_00_01_00_001);

        // jumps
        fetch_dcd("jal", 6'h03, 6'h00);
        cyc("jal_jmp", 1'b0, 6'h03, 6'h00, 1'b0, 1'b0, 4'd10, 6'b101000, 12'b0_10_10_10_00_000);
        fetch_dcd("j", 6'h02, 6'h00);
        cyc("j_jmp",   1'b0, 6'h02, 6'h00, 1'b0, 1'b0, 4'd10, 6'b100000, 12'b0_00_00_10_00_000);
        fetch_dcd("jr", 6'h00, 6'h08);
        cyc("jr_jmp",  1'b0, 6'h00, 6'h08, 1'b0, 1'b0, 4'd10, 6'b100000, 12'b0_00_00_11_00_000);

        // illegal opcode and illegal funct: FETCH, DCD, back to FETCH
        fetch_dcd("ill_op", 6'h3F, 6'h00);
        fetch_dcd("ill_fn", 6'h00, 6'h20);

        // reset in MEM_RD: outputs forced low in the reset cycle, FETCH next
        fetch_dcd("rstmem", 6'h23, 6'h00);
        cyc("rstmem_madr", 1'b0, 6'h23, 6'h00, 1'b0, 1'b0, 4'd4, 6'b000000, SEL_MEM);
        cyc("rstmem_rd",   1'b0, 6'h23, 6'h00, 1'b0, 1'b0, 4'd5, 6'b000010, SEL_MEM);
        cyc("rstmem_rst",  1'b1, 6'h23, 6'h00, 1'b1, 1'b1, 4'd5, 6'b000000, 12'b0);

        // reset during DCD of an illegal opcode
        cyc("rstill_fetch", 1'b0, 6'h3F, 6'h00, 1'b0, 1'b0, 4'd0, 6'b110000, 12'b0);
        cyc("rstill_rst",   1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, 4'd1, 6'b000000, 12'b0);
        cyc("final_fetch",  1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 4'd0, 6'b110000, 12'b0);
        cyc("final_dcd",    1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 4'd1, 6'b000000, 12'b0);

        for (int unsigned i = 0; i < 10 && q_exp.size() != 0; i++)
            @(posedge clk);
        if (q_exp.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", q_exp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
